nibble_packer: RTL

NIBBLE_PACKER -- requirements
Module: nibble_packer

---
 rtl/nibble_packer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/nibble_packer.sv
// Packs a stream of 4-bit nibbles into 16-bit words (first nibble in [3:0]),
// with partial-word flush and a single-entry, zero-bubble output register.
module nibble_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        flush,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [2:0]  dout_nib,
    output logic [7:0]  word_cnt
);

    typedef enum logic [1:0] {ACC0 = 2'd0, ACC1 = 2'd1, ACC2 = 2'd2, ACC3 = 2'd3} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_acc;
    logic [15:0] r_dout;
    logic        r_dout_valid;
    logic [2:0]  r_dout_nib;
    logic [7:0]  r_word_cnt;

    logic        w_slot_free;
    logic        w_accept;
    logic        w_hs;
    logic        w_full;
    logic        w_flush;
    logic        w_load;
    logic [1:0]  w_fcnt;
    logic [15:0] w_word;
    logic [2:0]  w_nib;

    assign w_fcnt      = r_state;
    assign w_slot_free = !r_dout_valid || dout_ready;
    assign din_ready   = (r_state != ACC3) || w_slot_free;
    assign w_accept    = din_valid && din_ready;
    assign w_hs        = r_dout_valid && dout_ready;
    assign w_full      = w_accept && (r_state == ACC3);
    assign w_flush     = flush && w_slot_free && ((r_state != ACC0) || w_accept);
    assign w_load      = w_full || w_flush;

    // Word as it would leave this cycle: filled nibbles, the nibble being
    // accepted now, and zeros above. Stale accumulator contents are masked.
    always_comb begin
        w_word = '0;
        if (w_fcnt > 2'd0) w_word[3:0]  = r_acc[3:0];
        if (w_fcnt > 2'd1) w_word[7:4]  = r_acc[7:4];
        if (w_fcnt > 2'd2) w_word[11:8] = r_acc[11:8];
        if (w_accept) begin
            w_word[{w_fcnt, 2'b00} +: 4] = din;
        end
        w_nib = {1'b0, w_fcnt} + {2'b00, w_accept};
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = ACC0;
        end else if (w_accept) begin
            case (r_state)
                ACC0:    w_state_nxt = ACC1;
                ACC1:    w_state_nxt = ACC2;
                ACC2:    w_state_nxt = ACC3;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACC0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_accept && !w_load) begin
            case (r_state)
                ACC0:    r_acc[3:0]  <= din;
                ACC1:    r_acc[7:4]  <= din;
                ACC2:    r_acc[11:8] <= din;
                default: r_acc       <= r_acc;
            endcase
        end
    end

    // Output slot: a load wins over the handshake clear so back-to-back words
    // stream without a bubble; otherwise the word is held until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_nib   <= '0;
            r_word_cnt   <= '0;
        end else begin
            if (w_load) begin
                r_dout       <= w_word;
                r_dout_nib   <= w_nib;
                r_dout_valid <= 1'b1;
            end else if (w_hs) begin
                r_dout_valid <= 1'b0;
            end
            if (w_hs) begin
                r_word_cnt <= r_word_cnt + 8'd1;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_nib   = r_dout_nib;
    assign word_cnt   = r_word_cnt;

endmodule
